// File: rtl/ul_trig_capture_buffer_if.sv
// Bus bundle for ul_trig_capture_buffer: sample stream, trigger/arm controls,
// capture configuration, read-back port and status.
interface ul_trig_capture_buffer_if #(
  parameter int ADDR_W    = 11,
  parameter int HOLDOFF_W = 16
);
  logic signed [15:0]    x0_i;
  logic signed [15:0]    x0z_i;
  logic                  trigger_i;
  logic                  arm_i;
  logic                  abort_i;
  logic [HOLDOFF_W-1:0]  cfg_holdoff_i;
  logic [ADDR_W:0]       cfg_len_i;
  logic                  rd_en_i;
  logic [ADDR_W-1:0]     rd_addr_i;
  logic [31:0]           rd_data_o;
  logic                  rd_valid_o;
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_W:0]       wr_count_o;
  logic [31:0]           trig_ts_o;

  modport master (
    output x0_i, x0z_i, trigger_i, arm_i, abort_i, cfg_holdoff_i, cfg_len_i,
           rd_en_i, rd_addr_i,
    input  rd_data_o, rd_valid_o, busy_o, done_o, wr_count_o, trig_ts_o
  );

  modport slave (
    input  x0_i, x0z_i, trigger_i, arm_i, abort_i, cfg_holdoff_i, cfg_len_i,
           rd_en_i, rd_addr_i,
    output rd_data_o, rd_valid_o, busy_o, done_o, wr_count_o, trig_ts_o
  );
endinterface

// File: rtl/ul_trig_capture_buffer.sv
// Triggered capture of the two-samples-per-clock stream into block RAM with word read-back.
// Optional trigger timestamp enabled by defining UL_CAPTURE_TIMESTAMP_EN.
module ul_trig_capture_buffer #(
  parameter int ADDR_W    = 11,
  parameter int HOLDOFF_W = 16
) (
  input logic                    clk_i,
  input logic                    rst_i,
  ul_trig_capture_buffer_if.slave bus
);
  localparam int                   DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]      FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]      CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [HOLDOFF_W-1:0] HO_ONE   = HOLDOFF_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_HOLDOFF = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [HOLDOFF_W-1:0] holdoff_r, holdoff_s;
  logic [ADDR_W:0]      len_r, len_s, eff_len_s;
  logic [ADDR_W:0]      wr_count_r, wr_count_s;
  logic                 wr_en_s;
  logic                 busy_r, done_r;
  logic                 rd_valid_r;
  logic [31:0]          rd_data_r;
  logic [31:0]          mem_r [DEPTH];

  // Next-state, counter and write-enable decode; abort overrides everything.
  always_comb begin
    state_s    = state_r;
    holdoff_s  = holdoff_r;
    len_s      = len_r;
    wr_count_s = wr_count_r;
    wr_en_s    = 1'b0;
    if ((bus.cfg_len_i == '0) || (bus.cfg_len_i > FULL_LEN)) begin
      eff_len_s = FULL_LEN;
    end else begin
      eff_len_s = bus.cfg_len_i;
    end
    if (bus.abort_i) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.arm_i) begin
            state_s    = ST_ARMED;
            wr_count_s = '0;
          end else begin
            state_s = state_r;
          end
        end
        ST_ARMED: begin
          if (bus.trigger_i) begin
            len_s     = eff_len_s;
            holdoff_s = bus.cfg_holdoff_i;
            if (bus.cfg_holdoff_i == '0) begin
              state_s = ST_CAPTURE;
            end else begin
              state_s = ST_HOLDOFF;
            end
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_HOLDOFF: begin
          holdoff_s = holdoff_r - HO_ONE;
          if (holdoff_r == HO_ONE) begin
            state_s = ST_CAPTURE;
          end else begin
            state_s = ST_HOLDOFF;
          end
        end
        ST_CAPTURE: begin
          wr_en_s    = 1'b1;
          wr_count_s = wr_count_r + CNT_ONE;
          if ((wr_count_r + CNT_ONE) == len_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CAPTURE;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Control state, latched configuration and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      holdoff_r  <= '0;
      len_r      <= '0;
      wr_count_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      holdoff_r  <= holdoff_s;
      len_r      <= len_s;
      wr_count_r <= wr_count_s;
      busy_r     <= (state_s == ST_ARMED) || (state_s == ST_HOLDOFF) || (state_s == ST_CAPTURE);
      done_r     <= (state_s == ST_DONE);
    end
  end

  // Capture RAM write port; the address never wraps because capture stops at len_r.
  always_ff @(posedge clk_i) begin
    if (wr_en_s && !rst_i) begin
      mem_r[wr_count_r[ADDR_W-1:0]] <= {bus.x0z_i, bus.x0_i};
    end
  end

  // Read port: data is only exposed while no record is in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 32'd0;
    end else begin
      rd_valid_r <= bus.rd_en_i;
      if (bus.rd_en_i) begin
        rd_data_r <= ((state_r == ST_IDLE) || (state_r == ST_DONE)) ? mem_r[bus.rd_addr_i] : 32'd0;
      end
    end
  end

  assign bus.rd_data_o  = rd_data_r;
  assign bus.rd_valid_o = rd_valid_r;
  assign bus.busy_o     = busy_r;
  assign bus.done_o     = done_r;
  assign bus.wr_count_o = wr_count_r;

`ifdef UL_CAPTURE_TIMESTAMP_EN
  logic        trig_acc_s;
  logic [31:0] cyc_cnt_r;
  logic [31:0] trig_ts_r;

  assign trig_acc_s = (state_r == ST_ARMED) && bus.trigger_i && !bus.abort_i;

  // Free-running cycle counter and timestamp of the accepted trigger.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_cnt_r <= 32'd0;
      trig_ts_r <= 32'd0;
    end else begin
      cyc_cnt_r <= cyc_cnt_r + 32'd1;
      if (trig_acc_s) begin
        trig_ts_r <= cyc_cnt_r;
      end
    end
  end

  assign bus.trig_ts_o = trig_ts_r;
`else
  assign bus.trig_ts_o = 32'd0;
`endif
endmodule
